// File: rtl/button_pkg.sv
// Shared definitions for the button pulse generator.
//   - FSM state encoding (3-bit localparams, legacy-compatible)
//   - default timing constants for the top-level parameters
//   - is_pressed_state(): debounced level implied by a given state
package button_pkg;

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] DEB_PRESS   = 3'd1;
    localparam logic [2:0] HELD        = 3'd2;
    localparam logic [2:0] REPEAT      = 3'd3;
    localparam logic [2:0] DEB_RELEASE = 3'd4;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_HOLD_CYCLES     = 16;
    localparam int unsigned DEF_REPEAT_CYCLES   = 8;
    localparam int unsigned DEF_CNT_W           = 5;

    // The button counts as pressed from acceptance until the release is accepted,
    // so a release still being debounced keeps the level high.
    function automatic logic is_pressed_state(input logic [2:0] st);
        return (st == HELD) || (st == REPEAT) || (st == DEB_RELEASE);
    endfunction

endpackage

// File: rtl/button_pulse_gen_if.sv
// Signal bundle between the button source / counter side and button_pulse_gen.
//   button    : raw asynchronous button level, 1 = pressed
//   repeat_en : 1 enables auto-repeat while the button is held
//   enable    : one-cycle pulse per accepted press or repeat tick
//   pressed   : debounced button level
// master drives button/repeat_en and observes the outputs; slave is the generator.
interface button_pulse_gen_if;

    logic button;
    logic repeat_en;
    logic enable;
    logic pressed;

    modport master (
        output button,
        output repeat_en,
        input  enable,
        input  pressed
    );

    modport slave (
        input  button,
        input  repeat_en,
        output enable,
        output pressed
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clock : destination clock
//   clear : asynchronous active-low clear, both flops go to 0
//   din   : asynchronous input
//   dout  : synchronized output, lags din by two rising edges
module sync_2ff (
    input  logic clock,
    input  logic clear,
    input  logic din,
    output logic dout
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/button_pulse_gen.sv
// Debounces a raw push button and emits single-cycle enable pulses for a
// downstream counter, with optional auto-repeat while the button is held.
//   clock : system clock, rising edge
//   clear : asynchronous active-low reset
//   bus   : slave side of button_pulse_gen_if (button, repeat_en in;
//           enable, pressed out)
module button_pulse_gen
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input logic               clock,
    input logic               clear,
    button_pulse_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);

    logic             btn_s;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             timer_clr;
    logic             pulse;
    logic             enable_q;
    logic             pressed_q;

    sync_2ff u_sync (
        .clock (clock),
        .clear (clear),
        .din   (bus.button),
        .dout  (btn_s)
    );

    always_comb begin
        state_d   = state_q;
        timer_clr = 1'b0;
        pulse     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Timer parked at 0 so it cannot free-run while idle.
                timer_clr = 1'b1;
                if (btn_s) begin
                    state_d = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (timer_q == DEB_TC) begin
                    state_d = HELD;
                    pulse   = 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = DEB_RELEASE;
                end else if (!bus.repeat_en) begin
                    timer_clr = 1'b1;
                end else if (timer_q == HOLD_TC) begin
                    state_d = REPEAT;
                    pulse   = 1'b1;
                end
            end
            REPEAT: begin
                // Release and repeat disable both take priority over a tick.
                if (!btn_s) begin
                    state_d = DEB_RELEASE;
                end else if (!bus.repeat_en) begin
                    state_d = HELD;
                end else if (timer_q == REP_TC) begin
                    timer_clr = 1'b1;
                    pulse     = 1'b1;
                end
            end
            DEB_RELEASE: begin
                // A bounce back high returns to HELD without a new pulse.
                if (btn_s) begin
                    state_d = HELD;
                end else if (timer_q == DEB_TC) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d != state_q) || timer_clr) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            enable_q  <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            enable_q  <= pulse;
            pressed_q <= is_pressed_state(state_d);
        end
    end

    assign bus.enable  = enable_q;
    assign bus.pressed = pressed_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Self-checking bench for button_pulse_gen: directed scenarios plus random
// button/repeat/reset activity, compared cycle by cycle against a run-length
// model of debounce and repeat timing.
module tb_button_pulse_gen;

    localparam int DEB  = 4;
    localparam int HOLD = 16;
    localparam int REP  = 8;

    logic clock = 1'b0;
    logic clear = 1'b0;

    button_pulse_gen_if bus_if ();

    button_pulse_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP),
        .CNT_W           (5)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a 2-deep delay for the synchronizer, then run lengths.
    //   m_deb : debounced level
    //   m_run : consecutive samples disagreeing with m_deb
    //   m_age : edges since the last pulse / hold restart
    //   m_rep : first repeat pulse already issued in this hold
    logic m_s1, m_s2, m_deb, m_rep, m_pulse;
    int   m_run, m_age;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_rep = 0; m_pulse = 0;
        m_run = 0; m_age = 0;
    endtask

    task automatic model_edge(input logic btn, input logic ren);
        logic s;
        s       = m_s2;
        m_s2    = m_s1;
        m_s1    = btn;
        m_pulse = 0;
        if (!m_deb) begin
            if (s) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_deb = 1; m_run = 0; m_age = 0; m_rep = 0; m_pulse = 1;
                end
            end else begin
                m_run = 0;
            end
        end else if (!s) begin
            m_run++; m_age = 0; m_rep = 0;
            if (m_run == DEB + 1) begin
                m_deb = 0; m_run = 0;
            end
        end else if (m_run != 0) begin
            m_run = 0; m_age = 0; m_rep = 0;
        end else if (!ren) begin
            m_age = 0; m_rep = 0;
        end else begin
            m_age++;
            if ((!m_rep && m_age == HOLD) || (m_rep && m_age == REP)) begin
                m_pulse = 1; m_age = 0; m_rep = 1;
            end
        end
    endtask

    int   edge_no = 0;
    int   pulse_edges[$];
    int   press_falls = 0;
    logic prev_en = 0;
    logic prev_pr = 0;

    // Called at a falling edge: drive, take one rising edge, check at next fall.
    task automatic step(input logic btn, input logic ren);
        bus_if.button    = btn;
        bus_if.repeat_en = ren;
        @(posedge clock);
        edge_no++;
        model_edge(btn, ren);
        if (m_pulse) pulse_edges.push_back(edge_no);
        @(negedge clock);
        check_eq("enable", 32'(bus_if.enable), 32'(m_pulse));
        check_eq("pressed", 32'(bus_if.pressed), 32'(m_deb));
        check_eq("enable_back_to_back", 32'(prev_en & bus_if.enable), 32'd0);
        if (prev_pr && !bus_if.pressed) press_falls++;
        prev_en = bus_if.enable;
        prev_pr = bus_if.pressed;
    endtask

    task automatic do_reset(input int cycles);
        clear = 1'b0;
        #1;
        model_reset();
        check_eq("reset_enable", 32'(bus_if.enable), 32'd0);
        check_eq("reset_pressed", 32'(bus_if.pressed), 32'd0);
        repeat (cycles) begin
            @(negedge clock);
            check_eq("reset_hold_enable", 32'(bus_if.enable), 32'd0);
            check_eq("reset_hold_pressed", 32'(bus_if.pressed), 32'd0);
        end
        clear   = 1'b1;
        prev_en = 0;
        prev_pr = 0;
    endtask

    task automatic begin_scenario();
        repeat (14) step(1'b0, 1'b0);
        edge_no     = 0;
        press_falls = 0;
        pulse_edges.delete();
    endtask

    function automatic int pulse_at(input int idx);
        return (idx < pulse_edges.size()) ? pulse_edges[idx] : -1;
    endfunction

    // Downstream 3-bit up/down counter that turns around at its end values.
    logic [2:0] cnt;
    logic       cnt_up;

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            cnt    <= 3'd0;
            cnt_up <= 1'b1;
        end else if (bus_if.enable) begin
            if (cnt_up && cnt == 3'd7) begin
                cnt <= 3'd6; cnt_up <= 1'b0;
            end else if (!cnt_up && cnt == 3'd0) begin
                cnt <= 3'd1; cnt_up <= 1'b1;
            end else begin
                cnt <= cnt_up ? cnt + 3'd1 : cnt - 3'd1;
            end
        end
    end

    int exp_auto[6] = '{7, 23, 31, 39, 47, 55};
    int exp_cnt[9]  = '{1, 2, 3, 4, 5, 6, 7, 6, 5};

    initial begin
        logic found;
        logic lvl;
        logic ren;
        int   len;

        bus_if.button    = 1'b0;
        bus_if.repeat_en = 1'b0;
        model_reset();
        do_reset(3);

        // Clean press, no repeat.
        begin_scenario();
        repeat (40) step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        check_eq("clean_pulse_count", 32'(pulse_edges.size()), 32'd1);
        check_eq("clean_pulse_edge", 32'(pulse_at(0)), 32'd7);
        check_eq("clean_press_falls", 32'(press_falls), 32'd1);

        // Short bounces never get accepted.
        begin_scenario();
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        check_eq("bounce_pulse_count", 32'(pulse_edges.size()), 32'd0);
        check_eq("bounce_pressed", 32'(bus_if.pressed), 32'd0);

        // Auto-repeat.
        begin_scenario();
        repeat (60) step(1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b1);
        check_eq("repeat_pulse_count", 32'(pulse_edges.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_eq("repeat_pulse_edge", 32'(pulse_at(i)), 32'(exp_auto[i]));
        end

        // Release bounce.
        begin_scenario();
        repeat (20) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        check_eq("relbounce_pulse_count", 32'(pulse_edges.size()), 32'd1);
        check_eq("relbounce_press_falls", 32'(press_falls), 32'd1);

        // Reset mid-debounce with the button still held.
        begin_scenario();
        repeat (4) step(1'b1, 1'b0);
        do_reset(3);
        edge_no = 0;
        pulse_edges.delete();
        repeat (12) step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        check_eq("rst_deb_pulse_count", 32'(pulse_edges.size()), 32'd1);
        check_eq("rst_deb_pulse_edge", 32'(pulse_at(0)), 32'(DEB + 3));

        // Reset while enable is high must drop it at once.
        begin_scenario();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0);
            found = m_pulse;
        end
        check_eq("pulse_seen_before_reset", 32'(found), 32'd1);
        do_reset(2);
        repeat (12) step(1'b0, 1'b0);

        // Counter integration: nine clean presses from a cleared counter.
        do_reset(2);
        for (int i = 0; i < 9; i++) begin
            repeat (8) step(1'b1, 1'b0);
            repeat (12) step(1'b0, 1'b0);
            check_eq("counter_value", 32'(cnt), 32'(exp_cnt[i]));
        end

        // Random button levels, repeat toggling and occasional resets.
        ren = 1'b0;
        for (int seg = 0; seg < 300; seg++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 3) == 0) ren = ~ren;
            if ($urandom_range(0, 49) == 0) do_reset($urandom_range(1, 3));
            repeat (len) step(lvl, ren);
        end
        repeat (40) step(1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
